// File: rtl/pulse_decoder.sv
// Sequenced binary-to-one-hot decoder: latches an accepted code, drives its
// output line for PULSE_LEN cycles, then holds all lines low for GAP_LEN cycles.
//
// state | meaning
// IDLE  | waiting for code_valid; code_ready high unless in reset
// DRIVE | one-hot pulse on out[code_q]; done on the last cycle
// GAP   | quiet period, all outputs low, requests ignored
module pulse_decoder #(
  parameter int CODE_W    = 3,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CODE_W-1:0]        code,
  input  logic                     code_valid,
  output logic                     code_ready,
  output logic [(1<<CODE_W)-1:0]   out,
  output logic                     busy,
  output logic                     done
);

  localparam int OUT_W = 1 << CODE_W;
  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W = $clog2(MAX_LEN) + 1;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CODE_W-1:0] code_q, code_nx;
  logic [OUT_W-1:0]  out_nx;
  logic              busy_nx, done_nx;

  assign code_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      code_q <= '0;
      out    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      code_q <= code_nx;
      out    <= out_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    code_nx  = code_q;
    case (state)
      IDLE: begin
        if (code_valid) begin
          code_nx  = code;
          cnt_nx   = PULSE_LD;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          if (GAP_LEN > 0) begin
            state_nx = GAP;
            cnt_nx   = GAP_LD;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are computed from the next state so they register alongside it.
    out_nx  = (state_nx == DRIVE) ? (OUT_W'(1) << code_nx) : '0;
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DRIVE) && (cnt_nx == '0);
  end

endmodule

// File: tb/tb_pulse_decoder.sv
// Bench for pulse_decoder: two instances (default timing and PULSE_LEN=1/GAP_LEN=0)
// checked every cycle against a timeline model, plus directed spacing checks.
module tb_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] c0 = '0, c1 = '0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic       ready0, ready1, busy0, busy1, done0, done1;
  logic [7:0] out0, out1;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_decoder #(.CODE_W(3), .PULSE_LEN(4), .GAP_LEN(1)) dut0 (
    .clk(clk), .rst(rst), .code(c0), .code_valid(v0), .code_ready(ready0),
    .out(out0), .busy(busy0), .done(done0));

  pulse_decoder #(.CODE_W(3), .PULSE_LEN(1), .GAP_LEN(0)) dut1 (
    .clk(clk), .rst(rst), .code(c1), .code_valid(v1), .code_ready(ready1),
    .out(out1), .busy(busy1), .done(done1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Timeline model: k counts cycles since acceptance (0 = idle). Pulse occupies
  // k = 1..P, gap occupies k = P+1..P+G.
  int         plen[2] = '{4, 1};
  int         glen[2] = '{1, 0};
  int         k[2] = '{0, 0};
  logic [2:0] mc[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic       v;
      logic [2:0] c;
      v = (i == 0) ? v0 : v1;
      c = (i == 0) ? c0 : c1;
      if (rst) k[i] = 0;
      else if (k[i] == 0) begin
        if (v) begin
          k[i]  = 1;
          mc[i] = c;
        end
      end else if (k[i] >= plen[i] + glen[i]) k[i] = 0;
      else k[i] = k[i] + 1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e_out;
      e_out = (k[i] >= 1 && k[i] <= plen[i]) ? (8'd1 << mc[i]) : 8'd0;
      if (i == 0) begin
        check("out0", out0, e_out);
        check("done0", done0, k[0] == plen[0]);
        check("busy0", busy0, k[0] != 0);
        check("ready0", ready0, (k[0] == 0) && !rst);
      end else begin
        check("out1", out1, e_out);
        check("done1", done1, k[1] == plen[1]);
        check("busy1", busy1, k[1] != 0);
        check("ready1", ready1, (k[1] == 0) && !rst);
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Waits for a busy rising edge on the selected instance; returns its cycle.
  task automatic wait_rise(input int idx, output int t);
    logic prev, now;
    bit   found;
    prev  = (idx == 0) ? busy0 : busy1;
    found = 0;
    t     = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      nxt();
      now = (idx == 0) ? busy0 : busy1;
      if (now && !prev) begin
        found = 1;
        t     = cyc;
      end
      prev = now;
    end
    if (!found) check("accept_timeout", 0, 1);
  endtask

  initial begin
    int t_prev, t_now;
    rst = 1'b1; v0 = 1'b1; c0 = 3'd5;
    repeat (3) nxt();
    rst = 1'b0;
    #1 check("ready_after_rst", ready0, 1);

    // Single pulse of code 5 accepted on the first edge after release.
    wait_rise(0, t_now);
    v0 = 1'b0;
    repeat (8) nxt();

    // Sweep 7..0 with valid held high.
    v0 = 1'b1;
    t_prev = 0;
    for (int code = 7; code >= 0; code--) begin
      c0 = 3'(code);
      wait_rise(0, t_now);
      if (code < 7) check("sweep_spacing", t_now - t_prev, 6);
      t_prev = t_now;
    end
    v0 = 1'b0;
    repeat (8) nxt();

    // Backpressure: code changes during DRIVE must not affect the pulse.
    c0 = 3'd3; v0 = 1'b1;
    wait_rise(0, t_prev);
    c0 = 3'd6;
    wait_rise(0, t_now);
    check("bp_spacing", t_now - t_prev, 6);
    v0 = 1'b0;
    repeat (8) nxt();

    // Back-to-back on the PULSE_LEN=1, GAP_LEN=0 instance.
    c1 = 3'd1; v1 = 1'b1;
    wait_rise(1, t_prev);
    c1 = 3'd2;
    wait_rise(1, t_now);
    check("b2b_spacing", t_now - t_prev, 2);
    v1 = 1'b0;
    repeat (4) nxt();

    // Reset in the second DRIVE cycle of code 4.
    c0 = 3'd4; v0 = 1'b1;
    wait_rise(0, t_now);
    v0 = 1'b0;
    nxt();
    rst = 1'b1;
    nxt();
    check("midrst_busy", busy0, 0);
    check("midrst_out", out0, 0);
    rst = 1'b0;
    c0 = 3'd1; v0 = 1'b1;
    wait_rise(0, t_now);
    v0 = 1'b0;
    repeat (8) nxt();

    // Random traffic with occasional resets.
    repeat (400) begin
      nxt();
      rst = ($urandom_range(0, 49) == 0);
      v0  = $urandom_range(0, 1);
      v1  = $urandom_range(0, 1);
      c0  = 3'($urandom_range(0, 7));
      c1  = 3'($urandom_range(0, 7));
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    repeat (10) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pulse_decoder.md
# pulse_decoder

Sequenced binary-to-one-hot decoder that consumes the `{code, valid}` pair produced by the 8-input priority encoder. It drives the selected output line as a fixed-width pulse, then enforces a quiet gap before it accepts the next code. It sits downstream of the encoder, for example in interrupt/strobe distribution. A ready/valid handshake applies backpressure while a pulse is in flight.

## Interface
- `CODE_W`, 3: code width; output width `OUT_W = 2**CODE_W` (8 by default).
- `PULSE_LEN`, 4: cycles the selected output stays high; legal range 1..255.
- `GAP_LEN`, 1: cycles all outputs stay low after a pulse; legal range 0..255.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `code`  in  CODE_W  index to decode (encoder `out`).
- `code_valid`  in  1  `code` is meaningful (encoder `valid`).
- `code_ready`  out  1  block can accept a code this cycle.
- `out`  out  OUT_W  one-hot pulse output; all-zero when idle or in gap.
- `busy`  out  1  pulse or gap in progress.
- `done`  out  1  one-cycle strobe on the last pulse cycle.

## Operation
- The block has three states: IDLE, DRIVE and GAP.
- Reset values: state IDLE, `out`=0, `busy`=0, `done`=0, counter=0. `code_ready`=0 while `rst` is high.
- `code_ready` = (state==IDLE) && !rst. It is combinational from state and does not depend on `code_valid`.
- Accept: `code_valid && code_ready` at a rising edge. `code` is latched, the counter loads PULSE_LEN-1, and the state goes to DRIVE.
- DRIVE:
  - `out` = 1<<code_latched, registered, with exactly one bit set.
  - The counter decrements each cycle.
  - When the counter is 0: `done`=1 for that cycle. The next state is GAP with the counter loaded to GAP_LEN-1 if GAP_LEN>0; otherwise the next state is IDLE.
- GAP:
  - `out`=0.
  - The counter decrements; at 0 the next state is IDLE.
- `busy` = (state!=IDLE), registered with the state.
- Code 0 with `code_valid`=1 is a legitimate request and drives `out[0]`.
- `code_valid`=0 in IDLE leaves the block in IDLE with `out`=0, whatever value is on `code`.
- `code` and `code_valid` are ignored outside IDLE. No queuing takes place: upstream must hold the request until `code_ready` is seen.
- No arithmetic wraps. The counter width is clog2(max(PULSE_LEN,GAP_LEN))+1 and it never decrements below 0.
- Reset mid-DRIVE or mid-GAP: on the next edge `out`=0, `busy`=0, `done`=0 and the state is IDLE. The latched code is discarded.

## Timing
- An accept at edge t produces `out` one-hot in cycles t+1 .. t+PULSE_LEN.
- `done` is high only in cycle t+PULSE_LEN.
- GAP covers cycles t+PULSE_LEN+1 .. t+PULSE_LEN+GAP_LEN.
- `code_ready` returns high in cycle t+PULSE_LEN+GAP_LEN+1.
- Minimum accept-to-accept spacing is PULSE_LEN+GAP_LEN+1 cycles, which is 6 with the defaults.
- `busy` is high exactly during DRIVE and GAP. It is never high in the same cycle as `code_ready`.
- Latency from accept to first output edge is 1 cycle.
- No combinational path exists from `code` or `code_valid` to any output.

## Test plan
- Reset check: hold `rst` for 2 cycles with `code_valid`=1, `code`=5 -> `out`=0, `busy`=0, `done`=0 and `code_ready`=0 during reset. `code_ready`=1 the first cycle after release, and nothing is accepted during reset.
- Single pulse, defaults: accept `code`=5 at edge t -> `out`=8'h20 for t+1..t+4, `done` only at t+4, `out`=0 at t+5, `code_ready`=1 at t+6.
- Full sweep with `code_valid` held high and `code` changed after each accept over 7,6,...,0 -> `out` takes the values 8'h80, 8'h40, ..., 8'h01 in order. Accepts are exactly 6 cycles apart, and each pulse has exactly one bit set and lasts 4 cycles.
- Backpressure: change `code` 3 -> 6 during DRIVE while `code_valid`=1 -> the pulse stays 8'h08. Code 6 is accepted only when `code_ready` returns.
- GAP_LEN=0, PULSE_LEN=1: back-to-back accepts of codes 1 and 2 -> `out`=8'h02 then 8'h00 then 8'h04, accepts 2 cycles apart, and `done` high every pulse cycle.
- Reset mid-operation: assert `rst` in the 2nd DRIVE cycle of code 4 -> next cycle `out`=0, `busy`=0, IDLE. A fresh accept of `code`=1 after release gives a full 4-cycle pulse of 8'h02.
